// File: rtl/mult_sched_pkg.sv
// Shared widths, FSM state and bundle types for the shared
// multiplier scheduler.
package mult_sched_pkg;

  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 16;
  localparam int COUNT_W   = 16;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } mult_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit above ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wallace_tree_signed.sv
// Combinational 8x8 two's complement multiplier, full 16-bit product.
// The MSB partial product carries negative weight.
module wallace_tree_signed (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  logic [15:0] ext_a;
  logic [15:0] acc;

  always_comb begin
    ext_a = {{8{a[7]}}, a};
    acc   = '0;
    for (int i = 0; i < 7; i++) begin
      if (b[i]) acc = acc + (ext_a << i);
    end
    if (b[7]) acc = acc - (ext_a << 7);
  end

  assign p = acc;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin share of one signed 8x8 multiplier between NUM_REQ clients.
// Define MULT_RR_SCHEDULER_STATS_EN for per-requester grant counters.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_a,
  input  logic [NUM_REQ*8-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  output logic [15:0]            resp_product,
  output logic [ID_W-1:0]        resp_id,
  input  logic                   resp_ready,
  output logic [NUM_REQ*16-1:0]  grant_count
);

  state_t                 state;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        id_q;
  logic [ID_W-1:0]        gidx;
  logic [NUM_REQ-1:0]     grant;
  mult_op_t               op;
  logic [PRODUCT_W-1:0]   prod;
  logic                   idle;
  logic                   accept;

  assign idle = (state == IDLE) && rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (idle),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & req_ready);

  wallace_tree_signed u_mult (
    .a (op.a),
    .b (op.b),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      op           <= '0;
      resp_valid   <= 1'b0;
      resp_product <= '0;
      resp_id      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op.a  <= req_a[gidx*OPERAND_W +: OPERAND_W];
            op.b  <= req_b[gidx*OPERAND_W +: OPERAND_W];
            id_q  <= gidx;
            ptr   <= gidx;
            state <= CALC;
          end
        end
        CALC: begin
          resp_product <= prod;
          resp_id      <= id_q;
          resp_valid   <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_RR_SCHEDULER_STATS_EN
  logic [COUNT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (accept && cnt[gidx] != COUNT_MAX) begin
      cnt[gidx] <= cnt[gidx] + COUNT_W'(1);
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_count[i*COUNT_W +: COUNT_W] = cnt[i];
    end
  end
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Self-checking bench for mult_rr_scheduler: vector table, directed
// corner sequences and randomized traffic against a transaction model.
module tb_mult_rr_scheduler;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*8-1:0]  req_a;
  logic [N*8-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic [15:0]     resp_product;
  logic [IDW-1:0]  resp_id;
  logic            resp_ready;
  logic [N*16-1:0] grant_count;

  always #5 clk = ~clk;

  mult_rr_scheduler #(
    .NUM_REQ (N),
    .ID_W    (IDW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_id      (resp_id),
    .resp_ready   (resp_ready),
    .grant_count  (grant_count)
  );

  int checks   = 0;
  int failures = 0;

  // transaction model: one job in flight, result visible two edges after accept
  int          m_ptr   = N - 1;
  bit          m_known = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_rv    = 1'b0;
  logic [15:0] m_prod  = '0;
  int          m_id    = 0;
  int          gc [N];
  logic [N-1:0] seen_ready;

  typedef struct {
    int          r;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    int pick;
    int pa;
    int pb;
    logic [N-1:0]    er;
    logic [N*16-1:0] eg;
    #1;
    pick = -1;
    if (rst_n === 1'b1 && !m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      end
    end
    er = '0;
    if (pick >= 0) er[pick] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    seen_ready = req_ready;
    if (m_known) begin
      check("resp_valid", 64'(resp_valid), 64'(m_rv));
      if (m_rv) begin
        check("resp_product", 64'(resp_product), 64'(m_prod));
        check("resp_id", 64'(resp_id), 64'(m_id));
      end
      eg = '0;
`ifdef MULT_RR_SCHEDULER_STATS_EN
      for (int i = 0; i < N; i++) eg[i*16 +: 16] = 16'(gc[i]);
`endif
      check("grant_count", 64'(grant_count), 64'(eg));
    end
    @(posedge clk);
    if (rst_n !== 1'b1) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_rv    = 1'b0;
      m_ptr   = N - 1;
      for (int i = 0; i < N; i++) gc[i] = 0;
    end else if (m_rv) begin
      if (resp_ready) begin
        m_rv   = 1'b0;
        m_busy = 1'b0;
      end
    end else if (m_busy) begin
      m_rv = 1'b1;
    end else if (pick >= 0) begin
      pa     = $signed(req_a[pick*8 +: 8]);
      pb     = $signed(req_b[pick*8 +: 8]);
      m_prod = 16'(pa * pb);
      m_id   = pick;
      m_ptr  = pick;
      m_busy = 1'b1;
      if (gc[pick] < 65535) gc[pick]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_one(input int r, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output logic [15:0] prod,
                         output int id);
    int n;
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_valid       = '0;
    req_valid[r]    = 1'b1;
    resp_ready      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!seen_ready[r] && n < 10);
    check("accept_wait", 64'(seen_ready[r]), 64'd1);
    req_valid = '0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    prod = resp_product;
    id   = int'(resp_id);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [7];
    int          lat;
    int          id;
    logic [15:0] prod;
    int          nacc;
    int          np;
    int          ids [5];
    int          ts [5];
    logic [15:0] prods [5];

    tbl[0] = '{0, 8'hAA, 8'h55, 16'hE372};
    tbl[1] = '{2, 8'h80, 8'h80, 16'h4000};
    tbl[2] = '{2, 8'h7F, 8'h80, 16'hC080};
    tbl[3] = '{2, 8'hFF, 8'hFF, 16'h0001};
    tbl[4] = '{2, 8'h00, 8'h7F, 16'h0000};
    tbl[5] = '{1, 8'h7F, 8'h7F, 16'h3F01};
    tbl[6] = '{3, 8'h9C, 8'h03, 16'hFED4};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) gc[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_one(tbl[i].r, tbl[i].a, tbl[i].b, lat, prod, id);
      check("vec_product", 64'(prod), 64'(tbl[i].p));
      check("vec_id", 64'(id), 64'(tbl[i].r));
      check("vec_latency", 64'(lat), 64'd2);
    end

    // all requesters valid: strict rotation, accepts three cycles apart
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[i*8 +: 8] = 8'hFF;
      req_b[i*8 +: 8] = 8'(i + 1);
      ids[i] = -1;
    end
    ids[4]     = -1;
    req_valid  = '1;
    resp_ready = 1'b1;
    nacc = 0;
    np   = 0;
    for (int t = 0; t < 20 && nacc < 5; t++) begin
      tick();
      if (seen_ready != '0) begin
        for (int i = 0; i < N; i++) if (seen_ready[i]) ids[nacc] = i;
        ts[nacc] = t;
        nacc++;
      end
      if (resp_valid === 1'b1 && np < 5) begin
        prods[np] = resp_product;
        np++;
      end
    end
    req_valid = '0;
    check("rr_accepts", 64'(nacc), 64'd5);
    check("rr_responses", 64'(np >= 4), 64'd1);
    for (int k = 0; k < nacc; k++) begin
      check("rr_order", 64'(ids[k]), 64'(k % N));
      if (k > 0) check("rr_spacing", 64'(ts[k] - ts[k-1]), 64'd3);
    end
    for (int k = 0; k < np && k < 4; k++) begin
      check("rr_product", 64'(prods[k]), 64'(16'hFFFF - 16'(k)));
    end
    for (int i = 0; i < 3; i++) tick();

    // backpressure: response held, no grants, next accept right after retire
    do_reset();
    req_a[7:0]   = 8'h05;
    req_b[7:0]   = 8'h07;
    req_a[23:16] = 8'h11;
    req_b[23:16] = 8'h02;
    req_valid    = 4'b0101;
    resp_ready   = 1'b0;
    tick();
    check("bp_first_grant", 64'(seen_ready), 64'b0001);
    req_valid = 4'b0100;
    tick();
    tick();
    check("bp_resp_valid", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_product", 64'(resp_product), 64'h0023);
      check("bp_hold_id", 64'(resp_id), 64'd0);
      check("bp_no_ready", 64'(seen_ready), 64'd0);
    end
    resp_ready = 1'b1;
    tick();
    check("bp_retire", 64'(resp_valid), 64'd0);
    tick();
    check("bp_next_accept", 64'(seen_ready), 64'b0100);
    req_valid = '0;
    for (int i = 0; i < 3; i++) tick();

    // reset while holding a result discards it and restores priority
    do_reset();
    req_valid  = 4'b0010;
    resp_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    tick();
    check("rd_in_done", 64'(resp_valid), 64'd1);
    req_valid = 4'b1001;
    rst_n     = 1'b0;
    tick();
    check("rd_ready_in_reset", 64'(seen_ready), 64'd0);
    rst_n = 1'b1;
    check("rd_valid_cleared", 64'(resp_valid), 64'd0);
    resp_ready = 1'b1;
    tick();
    check("rd_grant_zero", 64'(seen_ready), 64'b0001);
    req_valid = '0;
    for (int i = 0; i < 3; i++) tick();

    // grant counters
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_one(1, 8'(i), 8'h03, lat, prod, id);
    end
    for (int i = 0; i < 3; i++) begin
      run_one(3, 8'hF0, 8'(i), lat, prod, id);
    end
`ifdef MULT_RR_SCHEDULER_STATS_EN
    check("stats_counts", 64'(grant_count), 64'h0003_0000_000A_0000);
`else
    check("stats_counts", 64'(grant_count), 64'h0);
`endif

    // randomized traffic with withdrawals, backpressure and resets
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (seen_ready[i] || !req_valid[i]) begin
          req_valid[i]    = ($urandom_range(0, 2) != 0);
          req_a[i*8 +: 8] = 8'($urandom);
          req_b[i*8 +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n      = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
